mandelbrot_coord_gen: RTL and testbench

Pixel-coordinate source for the Mandelbrot pipeline. On a start pulse it latches a viewport (top-left corner plus step size) and raster-scans a frame of H_RES x V_RES pixels. For each pixel it emits one complex coordinate (cr, ci) on a valid/ready stream that feeds the iteration unit's cr/ci/valid_in inputs. It also emits pixel position and frame/line markers, which downstream colouring and video-write logic use to place each result.

---
 rtl/mandelbrot_pkg.sv | 28 ++
 rtl/mandelbrot_coord_gen_if.sv | 43 ++++
 rtl/mandelbrot_coord_gen.sv | 179 +++++++++++++++++
 tb/tb_mandelbrot_coord_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_pkg
// Description : Shared definitions for the Mandelbrot pipeline. Holds the
//               Q4.28 fixed-point format used by both the coordinate
//               generator and the iteration unit, the default frame geometry
//               and the coordinate generator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mandelbrot_pkg;

    // Q4.28 signed fixed point: 4 integer bits (incl. sign), 28 fraction bits
    localparam int              COORD_W   = 32;
    localparam int              FRAC_BITS = 28;
    localparam logic [31:0]     ONE       = 32'h1000_0000;

    // Default frame geometry
    localparam int              DEF_H_RES = 640;
    localparam int              DEF_V_RES = 480;

    // Coordinate generator state encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

endpackage : mandelbrot_pkg
`default_nettype wire

// File: rtl/mandelbrot_coord_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_coord_gen_if
// Description : Valid/ready coordinate stream between the coordinate
//               generator (master) and the iteration unit / pixel placement
//               logic (slave).
//   cr, ci     : complex coordinate of the beat, Q4.28
//   x, y       : pixel column / row of the beat
//   sof        : beat is pixel (0,0)
//   eol        : beat is the last pixel of a line
//   eof        : beat is the last pixel of the frame
//   valid_out  : beat present (driven by master)
//   ready_in   : beat accepted (driven by slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface mandelbrot_coord_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    import mandelbrot_pkg::*;

    logic [COORD_W-1:0] cr;
    logic [COORD_W-1:0] ci;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic               sof;
    logic               eol;
    logic               eof;
    logic               valid_out;
    logic               ready_in;

    modport master (
        output cr, ci, x, y, sof, eol, eof, valid_out,
        input  ready_in
    );

    modport slave (
        input  cr, ci, x, y, sof, eol, eof, valid_out,
        output ready_in
    );

endinterface : mandelbrot_coord_gen_if
`default_nettype wire

// File: rtl/mandelbrot_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_coord_gen
// Description : Raster-scan coordinate source for the Mandelbrot pipeline.
//               A start pulse (while idle) latches the viewport and emits
//               H_RES x V_RES beats, one per pixel, on a valid/ready stream.
//               Coordinates are accumulated incrementally (no multiplier):
//               cr = x_start + x*step, ci = y_start - y*step, modulo 2^32.
// Ports       :
//   clk        in   clock
//   reset      in   synchronous, active-low reset
//   start      in   one-cycle frame request, honoured only while idle
//   x_start    in   real part of top-left pixel, Q4.28
//   y_start    in   imaginary part of top-left pixel, Q4.28
//   step       in   per-pixel increment, Q4.28
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last beat transfers
//   stream     master side of mandelbrot_coord_gen_if
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic [COORD_W-1:0] x_start,
    input  wire logic [COORD_W-1:0] y_start,
    input  wire logic [COORD_W-1:0] step,
    output logic                    busy,
    output logic                    frame_done,
    mandelbrot_coord_gen_if.master  stream
);

    localparam logic [XW-1:0] c_x_last = XW'(H_RES - 1);
    localparam logic [YW-1:0] c_y_last = YW'(V_RES - 1);

    gen_state_t         r_state;
    logic [COORD_W-1:0] r_x_start;
    logic [COORD_W-1:0] r_step;
    logic [COORD_W-1:0] r_cr;
    logic [COORD_W-1:0] r_ci;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_valid;
    logic               r_busy;
    logic               r_frame_done;

    gen_state_t         w_state_nxt;
    logic [COORD_W-1:0] w_x_start_nxt;
    logic [COORD_W-1:0] w_step_nxt;
    logic [COORD_W-1:0] w_cr_nxt;
    logic [COORD_W-1:0] w_ci_nxt;
    logic [XW-1:0]      w_x_nxt;
    logic [YW-1:0]      w_y_nxt;
    logic               w_valid_nxt;
    logic               w_busy_nxt;
    logic               w_frame_done_nxt;

    logic               w_xfer;
    logic               w_last_col;
    logic               w_last_row;

    assign w_xfer     = r_valid & stream.ready_in;
    assign w_last_col = (r_x == c_x_last);
    assign w_last_row = (r_y == c_y_last);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_x_start    <= '0;
            r_step       <= '0;
            r_cr         <= '0;
            r_ci         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x_start    <= w_x_start_nxt;
            r_step       <= w_step_nxt;
            r_cr         <= w_cr_nxt;
            r_ci         <= w_ci_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_valid      <= w_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-datapath logic. Every register holds unless a start
    // is accepted in IDLE or a beat transfers in RUN, which keeps the beat
    // stable under backpressure.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_x_start_nxt    = r_x_start;
        w_step_nxt       = r_step;
        w_cr_nxt         = r_cr;
        w_ci_nxt         = r_ci;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_valid_nxt      = r_valid;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    // ci is loaded directly from y_start and only ever
                    // decremented, so y_start itself need not be kept.
                    w_x_start_nxt = x_start;
                    w_step_nxt    = step;
                    w_cr_nxt      = x_start;
                    w_ci_nxt      = y_start;
                    w_x_nxt       = '0;
                    w_y_nxt       = '0;
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = RUN;
                end
            end

            RUN: begin
                if (w_xfer) begin
                    if (!w_last_col) begin
                        w_x_nxt  = r_x + XW'(1);
                        w_cr_nxt = r_cr + r_step;
                    end else if (!w_last_row) begin
                        // Next line: rows descend the imaginary axis
                        w_x_nxt  = '0;
                        w_y_nxt  = r_y + YW'(1);
                        w_cr_nxt = r_x_start;
                        w_ci_nxt = r_ci - r_step;
                    end else begin
                        // eof beat accepted; coordinates simply hold
                        w_valid_nxt      = 1'b0;
                        w_busy_nxt       = 1'b0;
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. Markers are qualified by valid so they read 0 whenever no
    // beat is present (x=y=0 after reset would otherwise decode as sof).
    // ------------------------------------------------------------------------
    assign stream.cr        = r_cr;
    assign stream.ci        = r_ci;
    assign stream.x         = r_x;
    assign stream.y         = r_y;
    assign stream.valid_out = r_valid;
    assign stream.sof       = r_valid & (r_x == '0) & (r_y == '0);
    assign stream.eol       = r_valid & w_last_col;
    assign stream.eof       = r_valid & w_last_col & w_last_row;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;

endmodule : mandelbrot_coord_gen
`default_nettype wire

// File: tb/tb_mandelbrot_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandelbrot_coord_gen
// Description : Self-checking bench for mandelbrot_coord_gen with a 4x3
//               frame. Expected beats come from the closed-form coordinate
//               rule (x_start + x*step, y_start - y*step) indexed by the
//               beat number.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mandelbrot_coord_gen;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int XW   = 2;
    localparam int YW   = 2;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x_start;
    logic [31:0] y_start;
    logic [31:0] step;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    mandelbrot_coord_gen_if #(.XW(XW), .YW(YW)) s_if ();

    mandelbrot_coord_gen #(
        .H_RES (H),
        .V_RES (V),
        .XW    (XW),
        .YW    (YW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_start    (x_start),
        .y_start    (y_start),
        .step       (step),
        .busy       (busy),
        .frame_done (frame_done),
        .stream     (s_if.master)
    );

    always #5 clk = ~clk;

    // Observed bundle: valid, busy, frame_done, cr, ci, x, y, sof, eol, eof
    function automatic logic [73:0] observed();
        return {s_if.valid_out, busy, frame_done, s_if.cr, s_if.ci,
                s_if.x, s_if.y, s_if.sof, s_if.eol, s_if.eof};
    endfunction

    // Reference beat n of a frame with the given viewport
    function automatic logic [73:0] ref_beat(input logic [31:0] xs, input logic [31:0] ys,
                                             input logic [31:0] st, input int n);
        int          px, py;
        logic [31:0] ecr, eci;
        px  = n % H;
        py  = n / H;
        ecr = xs + 32'(px) * st;
        eci = ys - 32'(py) * st;
        return {1'b1, 1'b1, 1'b0, ecr, eci, XW'(px), YW'(py),
                (n == 0), (px == H - 1), (n == NPIX - 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start from the current (idle) sampling point, then follows the
    // frame to its frame_done cycle, comparing every visible beat with the
    // reference. Returns at the sampling point of the frame_done cycle.
    task automatic run_frame(input logic [31:0] xs, input logic [31:0] ys,
                             input logic [31:0] st, input bit rand_ready,
                             input int stall_beat, input bit disturb,
                             input bit start_on_eof, input string name);
        int        idx;
        int        cyc;
        int        stall_left;
        bit        rdy;
        logic [73:0] exp_v;
        logic [73:0] obs_v;
        x_start    = xs;
        y_start    = ys;
        step       = st;
        start      = 1'b1;
        s_if.ready_in = 1'b0;
        tick();
        start      = 1'b0;
        idx        = 0;
        cyc        = 0;
        stall_left = 5;
        while (idx < NPIX && cyc < 300) begin
            exp_v = ref_beat(xs, ys, st, idx);
            obs_v = observed();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL %s beat %0d: got %h, expected %h", name, idx, obs_v, exp_v);
            end
            if (idx == stall_beat && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            s_if.ready_in = rdy;
            start = (disturb && idx == 5) || (start_on_eof && idx == NPIX - 1);
            if (disturb && idx == 5) begin
                x_start = ~xs;
                y_start = ys + 32'h0123_4567;
                step    = st + 32'h0000_0300;
            end
            tick();
            if (rdy) idx++;
            cyc++;
        end
        start = 1'b0;
        s_if.ready_in = 1'b0;
        if (idx < NPIX) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d beats, expected %0d", name, idx, NPIX);
        end
        if (!rand_ready && stall_beat < 0) begin
            n_cmp++;
            if (cyc != NPIX) begin
                n_err++;
                $display("FAIL %s cycles: got %0d, expected %0d", name, cyc, NPIX);
            end
        end
        // frame_done cycle: valid=0, busy=0, frame_done=1
        n_cmp++;
        if ({s_if.valid_out, busy, frame_done} !== 3'b001) begin
            n_err++;
            $display("FAIL %s frame_done: got v/b/fd=%b, expected 001",
                     name, {s_if.valid_out, busy, frame_done});
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({s_if.valid_out, busy, frame_done, s_if.sof, s_if.eol, s_if.eof} !== 6'b0) begin
            n_err++;
            $display("FAIL %s idle: got v/b/fd/sof/eol/eof=%b, expected 000000", name,
                     {s_if.valid_out, busy, frame_done, s_if.sof, s_if.eol, s_if.eof});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        x_start = 32'h0;
        y_start = 32'h0;
        step = 32'h0;
        s_if.ready_in = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (observed() !== 74'h0) begin
            n_err++;
            $display("FAIL reset: got %h, expected %h", observed(), 74'h0);
        end
        reset = 1'b1;
        tick();
        check_idle("after_reset");
    endtask

    task automatic test_full_frame();
        run_frame(32'hF000_0000, 32'h1000_0000, 32'h0800_0000, 1'b0, -1, 1'b0, 1'b0, "full");
        tick();
        check_idle("full_post");
    endtask

    task automatic test_backpressure();
        run_frame(32'hF000_0000, 32'h1000_0000, 32'h0800_0000, 1'b1, 2, 1'b0, 1'b0, "bp");
        tick();
        check_idle("bp_post");
    endtask

    task automatic test_ignored_inputs();
        // Mid-frame start and viewport change, plus start on the eof cycle
        run_frame(32'hF000_0000, 32'h1000_0000, 32'h0800_0000, 1'b1, -1, 1'b1, 1'b1, "ign");
        tick();
        check_idle("ign_eof_start");
        tick();
        check_idle("ign_eof_start2");
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs, ys, st;
        for (int f = 0; f < 3; f++) begin
            xs = $urandom;
            ys = $urandom;
            st = $urandom;
            // Each start is issued in the previous frame's frame_done cycle
            run_frame(xs, ys, st, (f != 0), -1, 1'b0, 1'b0, "b2b");
        end
        tick();
        check_idle("b2b_post");
    endtask

    task automatic test_reset_mid();
        x_start = 32'hF000_0000;
        y_start = 32'h1000_0000;
        step    = 32'h0800_0000;
        start   = 1'b1;
        s_if.ready_in = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (observed() !== ref_beat(32'hF000_0000, 32'h1000_0000, 32'h0800_0000, 5)) begin
            n_err++;
            $display("FAIL rstmid beat5: got %h, expected %h", observed(),
                     ref_beat(32'hF000_0000, 32'h1000_0000, 32'h0800_0000, 5));
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        s_if.ready_in = 1'b0;
        n_cmp++;
        if (observed() !== 74'h0) begin
            n_err++;
            $display("FAIL rstmid zero: got %h, expected %h", observed(), 74'h0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle("rstmid_nofd");
        end
        run_frame(32'hF000_0000, 32'h1000_0000, 32'h0800_0000, 1'b0, -1, 1'b0, 1'b0, "rstmid_clean");
        tick();
    endtask

    task automatic test_wrap();
        run_frame(32'h7FFF_FFFF, 32'h8000_0002, 32'h0000_0001, 1'b0, -1, 1'b0, 1'b0, "wrap");
        tick();
        run_frame(32'h7FFF_FFF0, 32'h0000_0003, 32'h7000_0000, 1'b1, -1, 1'b0, 1'b0, "wrap2");
        tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mandelbrot_coord_gen
`default_nettype wire
